cpc_bank_ctrl: RTL and testbench

Synchronous bank-configuration controller for the CPC 512K RAM expansion, targeted at a single CPLD/FPGA that replaces the discrete 74-series decode. It samples Z80 bus cycles on the CPC clock and captures gate-array RAM-configuration writes (I/O write, A15=0, D7:D6=11) through a qualifying state machine. It holds the 6-bit configuration and maps each 16K memory block onto the external SRAM. From that mapping it drives RAMDIS, the SRAM chip select and SRAM address bits A18..A14.

---
 rtl/cpc_bank_pkg.sv | 40 ++++
 rtl/cpc_bank_map.sv | 33 +++
 rtl/cpc_bank_ctrl.sv | 113 +++++++++++
 tb/tb_cpc_bank_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpc_bank_pkg.sv
// Shared types, field positions and block-mapping rules for the CPC 512K bank controller.
package cpc_bank_pkg;

  localparam int unsigned CFG_W    = 6;
  localparam int unsigned BANK_MSB = 5;
  localparam int unsigned BANK_LSB = 3;
  localparam int unsigned MODE_MSB = 2;
  localparam int unsigned MODE_LSB = 0;
  localparam int unsigned CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_QUAL = 2'd2,
    ST_HOLD = 2'd3
  } cap_state_e;

  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_P1   = 3'd1;
  localparam logic [2:0] MODE_P2   = 3'd2;
  localparam logic [2:0] MODE_P3   = 3'd3;
  localparam logic [2:0] MODE_P4   = 3'd4;
  localparam logic [2:0] MODE_P5   = 3'd5;
  localparam logic [2:0] MODE_P6   = 3'd6;
  localparam logic [2:0] MODE_P7   = 3'd7;

  // Returns {mapped, page}; mode 3 leaves blk1 on internal RAM (page 3 is internal).
  function automatic logic [2:0] map_block(input logic [2:0] mode, input logic [1:0] blk);
    logic [2:0] r;
    r = 3'b000;
    case (mode)
      MODE_NONE:        r = 3'b000;
      MODE_P1, MODE_P3: r = (blk == 2'd3) ? 3'b111 : 3'b000;
      MODE_P2:          r = {1'b1, blk};
      default:          r = (blk == 2'd1) ? {1'b1, mode[1:0]} : 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpc_bank_map.sv
// Combinational block-to-SRAM mapping from the committed configuration and the live bus.
module cpc_bank_map
  import cpc_bank_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 8
) (
  input  logic [CFG_W-1:0] cfg_i,
  input  logic             a15_i,
  input  logic             a14_i,
  input  logic             mreq_b_i,
  input  logic             rfsh_b_i,
  output logic             ramdis_o,
  output logic             ramcs_b_o,
  output logic [4:0]       ramadrhi_o
);

  logic [2:0] bank_c;
  logic [2:0] mode_c;
  logic [2:0] map_c;
  logic       in_range_c;

  always_comb begin
    bank_c     = cfg_i[BANK_MSB:BANK_LSB];
    mode_c     = cfg_i[MODE_MSB:MODE_LSB];
    map_c      = map_block(mode_c, {a15_i, a14_i});
    in_range_c = (4'(bank_c) < 4'(NUM_BANKS));
    ramdis_o   = map_c[2] & in_range_c;
    ramadrhi_o = map_c[2] ? {bank_c, map_c[1:0]} : {bank_c, 2'b00};
    // Refresh cycles must never reach the SRAM.
    ramcs_b_o  = ~(ramdis_o & ~mreq_b_i & rfsh_b_i);
  end

endmodule

// File: rtl/cpc_bank_ctrl.sv
// Captures gate-array RAM-configuration writes through a qualifying FSM and drives the SRAM mapping.
module cpc_bank_ctrl
  import cpc_bank_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 8,
  parameter int unsigned QUAL_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET_B,
  input  logic             A15,
  input  logic             A14,
  input  logic [7:0]       D,
  input  logic             IOREQ_B,
  input  logic             WR_B,
  input  logic             M1_B,
  input  logic             MREQ_B,
  input  logic             RFSH_B,
  output logic             RAMDIS,
  output logic             ramcs_b,
  output logic [4:0]       ramadrhi,
  output logic [CFG_W-1:0] cfg_q,
  output logic             cfg_wr_p
);

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] held_q, held_d;
  logic [CFG_W-1:0] cfg_d;
  logic             wr_p_d;
  logic             qual_c;
  logic [CNT_W-1:0] cnt_inc_c;

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state_q  <= ST_ARM;
      cnt_q    <= '0;
      held_q   <= '0;
      cfg_q    <= '0;
      cfg_wr_p <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      cfg_q    <= cfg_d;
      cfg_wr_p <= wr_p_d;
    end
  end

  // Interrupt acknowledge (M1_B low) and upper-half I/O writes never qualify.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    cfg_d     = cfg_q;
    wr_p_d    = 1'b0;
    qual_c    = !IOREQ_B && !WR_B && M1_B && !A15 && (D[7:6] == 2'b11);
    cnt_inc_c = cnt_q + CNT_W'(1);

    case (state_q)
      ST_ARM: begin
        if (IOREQ_B) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (qual_c) begin
          held_d = D[5:0];
          cnt_d  = CNT_W'(1);
          if (QUAL_CYCLES <= 1) begin
            cfg_d   = D[5:0];
            wr_p_d  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_QUAL;
          end
        end
      end
      ST_QUAL: begin
        if (qual_c && (D[5:0] == held_q)) begin
          if (cnt_inc_c >= CNT_W'(QUAL_CYCLES)) begin
            cnt_d   = CNT_W'(QUAL_CYCLES);
            cfg_d   = held_q;
            wr_p_d  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (IOREQ_B) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  cpc_bank_map #(.NUM_BANKS(NUM_BANKS)) u_map (
    .cfg_i      (cfg_q),
    .a15_i      (A15),
    .a14_i      (A14),
    .mreq_b_i   (MREQ_B),
    .rfsh_b_i   (RFSH_B),
    .ramdis_o   (RAMDIS),
    .ramcs_b_o  (ramcs_b),
    .ramadrhi_o (ramadrhi)
  );

endmodule

// File: tb/tb_cpc_bank_ctrl.sv
// Directed bench for cpc_bank_ctrl: capture qualification, rejection cases, mapping and reset.
module tb_cpc_bank_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_B;
  logic       A15, A14;
  logic [7:0] D;
  logic       IOREQ_B, WR_B, M1_B, MREQ_B, RFSH_B;

  logic       ramdis, ramcs_b, cfg_wr_p;
  logic [4:0] ramadrhi;
  logic [5:0] cfg_q;
  logic       ramdis4, ramcs_b4, cfg_wr_p4;
  logic [4:0] ramadrhi4;
  logic [5:0] cfg_q4;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int pulses   = 0;

  always #5 CLK = ~CLK;

  cpc_bank_ctrl #(.NUM_BANKS(8), .QUAL_CYCLES(2)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .A15(A15), .A14(A14), .D(D),
    .IOREQ_B(IOREQ_B), .WR_B(WR_B), .M1_B(M1_B), .MREQ_B(MREQ_B), .RFSH_B(RFSH_B),
    .RAMDIS(ramdis), .ramcs_b(ramcs_b), .ramadrhi(ramadrhi),
    .cfg_q(cfg_q), .cfg_wr_p(cfg_wr_p)
  );

  cpc_bank_ctrl #(.NUM_BANKS(4), .QUAL_CYCLES(2)) dut4 (
    .CLK(CLK), .RESET_B(RESET_B), .A15(A15), .A14(A14), .D(D),
    .IOREQ_B(IOREQ_B), .WR_B(WR_B), .M1_B(M1_B), .MREQ_B(MREQ_B), .RFSH_B(RFSH_B),
    .RAMDIS(ramdis4), .ramcs_b(ramcs_b4), .ramadrhi(ramadrhi4),
    .cfg_q(cfg_q4), .cfg_wr_p(cfg_wr_p4)
  );

  always @(negedge CLK) if (cfg_wr_p) pulses++;

  task automatic set_bus(input logic a15, input logic a14, input logic mreq_b, input logic rfsh_b);
    A15 = a15; A14 = a14; MREQ_B = mreq_b; RFSH_B = rfsh_b;
    #1;
  endtask

  // I/O write held low for n clock edges, then released and idled two cycles.
  task automatic io_write(input logic [7:0] d, input logic a15, input logic m1_b, input int n);
    @(negedge CLK);
    D = d; A15 = a15; M1_B = m1_b; IOREQ_B = 1'b0; WR_B = 1'b0;
    repeat (n) @(negedge CLK);
    IOREQ_B = 1'b1; WR_B = 1'b1; M1_B = 1'b1; A15 = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset;
    RESET_B = 1'b0; IOREQ_B = 1'b1; WR_B = 1'b1; M1_B = 1'b1; D = 8'h00;
    set_bus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    #1;
    chk_cnt++; if (cfg_q !== 6'h00) $display("FAIL reset_cfg got=%h exp=00", cfg_q); else pass_cnt++;
    chk_cnt++; if (cfg_wr_p !== 1'b0) $display("FAIL reset_wrp got=%b exp=0", cfg_wr_p); else pass_cnt++;
    chk_cnt++; if ({ramdis, ramcs_b, ramadrhi} !== {1'b0, 1'b1, 5'd0})
      $display("FAIL reset_map got=%b%b%b exp=0100000", ramdis, ramcs_b, ramadrhi); else pass_cnt++;
    RESET_B = 1'b1;
    set_bus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic_write;
    int p0;
    p0 = pulses;
    io_write(8'hC2, 1'b0, 1'b1, 3);
    chk_cnt++; if (cfg_q !== 6'h02) $display("FAIL basic_cfg got=%h exp=02", cfg_q); else pass_cnt++;
    chk_cnt++; if (pulses - p0 !== 1) $display("FAIL basic_pulse got=%0d exp=1", pulses - p0); else pass_cnt++;
    set_bus(1'b1, 1'b0, 1'b0, 1'b1);
    chk_cnt++; if ({ramdis, ramcs_b, ramadrhi} !== {1'b1, 1'b0, 5'b00010})
      $display("FAIL basic_map got=%b%b%b exp=1000010", ramdis, ramcs_b, ramadrhi); else pass_cnt++;
    set_bus(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_mode5;
    logic [1:0] b;
    io_write(8'hED, 1'b0, 1'b1, 3);
    chk_cnt++; if (cfg_q !== 6'h2D) $display("FAIL m5_cfg got=%h exp=2d", cfg_q); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      b = 2'(i);
      set_bus(b[1], b[0], 1'b0, 1'b1);
      if (i == 1) begin
        chk_cnt++; if ({ramdis, ramcs_b, ramadrhi} !== {1'b1, 1'b0, 5'b10101})
          $display("FAIL m5_blk1 got=%b%b%b exp=1010101", ramdis, ramcs_b, ramadrhi); else pass_cnt++;
      end else begin
        chk_cnt++; if ({ramdis, ramcs_b} !== 2'b01)
          $display("FAIL m5_blk%0d got=%b%b exp=01", i, ramdis, ramcs_b); else pass_cnt++;
      end
    end
    set_bus(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_rejects;
    int p0;
    p0 = pulses;
    io_write(8'hC2, 1'b0, 1'b1, 1);
    chk_cnt++; if (cfg_q !== 6'h2D) $display("FAIL rej_short got=%h exp=2d", cfg_q); else pass_cnt++;
    io_write(8'h82, 1'b0, 1'b1, 3);
    chk_cnt++; if (cfg_q !== 6'h2D) $display("FAIL rej_d76 got=%h exp=2d", cfg_q); else pass_cnt++;
    io_write(8'hC2, 1'b1, 1'b1, 3);
    chk_cnt++; if (cfg_q !== 6'h2D) $display("FAIL rej_a15 got=%h exp=2d", cfg_q); else pass_cnt++;
    io_write(8'hC2, 1'b0, 1'b0, 3);
    chk_cnt++; if (cfg_q !== 6'h2D) $display("FAIL rej_inta got=%h exp=2d", cfg_q); else pass_cnt++;
    // Data changes between the two samples: must not commit either value.
    @(negedge CLK);
    D = 8'hC4; IOREQ_B = 1'b0; WR_B = 1'b0;
    @(negedge CLK);
    D = 8'hC5;
    @(negedge CLK);
    IOREQ_B = 1'b1; WR_B = 1'b1;
    repeat (2) @(negedge CLK);
    chk_cnt++; if (cfg_q !== 6'h2D) $display("FAIL rej_mismatch got=%h exp=2d", cfg_q); else pass_cnt++;
    chk_cnt++; if (pulses - p0 !== 0) $display("FAIL rej_pulse got=%0d exp=0", pulses - p0); else pass_cnt++;
  endtask

  task automatic test_mode3_min_qual;
    int p0;
    p0 = pulses;
    io_write(8'hC3, 1'b0, 1'b1, 2);
    chk_cnt++; if (cfg_q !== 6'h03) $display("FAIL m3_cfg got=%h exp=03", cfg_q); else pass_cnt++;
    chk_cnt++; if (pulses - p0 !== 1) $display("FAIL m3_pulse got=%0d exp=1", pulses - p0); else pass_cnt++;
    set_bus(1'b0, 1'b1, 1'b0, 1'b1);
    chk_cnt++; if ({ramdis, ramcs_b} !== 2'b01) $display("FAIL m3_blk1 got=%b%b exp=01", ramdis, ramcs_b); else pass_cnt++;
    set_bus(1'b1, 1'b1, 1'b0, 1'b1);
    chk_cnt++; if ({ramdis, ramcs_b, ramadrhi} !== {1'b1, 1'b0, 5'b00011})
      $display("FAIL m3_blk3 got=%b%b%b exp=1000011", ramdis, ramcs_b, ramadrhi); else pass_cnt++;
    set_bus(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_bank_limit;
    logic [1:0] b;
    io_write(8'hE1, 1'b0, 1'b1, 3);
    chk_cnt++; if (cfg_q4 !== 6'h21) $display("FAIL nb4_cfg got=%h exp=21", cfg_q4); else pass_cnt++;
    chk_cnt++; if (cfg_q !== 6'h21) $display("FAIL nb8_cfg got=%h exp=21", cfg_q); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      b = 2'(i);
      set_bus(b[1], b[0], 1'b0, 1'b1);
      chk_cnt++; if ({ramdis4, ramcs_b4} !== 2'b01)
        $display("FAIL nb4_blk%0d got=%b%b exp=01", i, ramdis4, ramcs_b4); else pass_cnt++;
    end
    set_bus(1'b1, 1'b1, 1'b0, 1'b1);
    chk_cnt++; if ({ramdis, ramcs_b, ramadrhi} !== {1'b1, 1'b0, 5'b10011})
      $display("FAIL nb8_blk3 got=%b%b%b exp=1010011", ramdis, ramcs_b, ramadrhi); else pass_cnt++;
  endtask

  task automatic test_refresh;
    set_bus(1'b1, 1'b1, 1'b0, 1'b0);
    chk_cnt++; if ({ramdis, ramcs_b} !== 2'b11) $display("FAIL rfsh got=%b%b exp=11", ramdis, ramcs_b); else pass_cnt++;
    set_bus(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_in_qual;
    int p0;
    p0 = pulses;
    @(negedge CLK);
    D = 8'hC7; IOREQ_B = 1'b0; WR_B = 1'b0;
    @(negedge CLK);
    RESET_B = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_B = 1'b1;
    repeat (3) @(negedge CLK);
    chk_cnt++; if (cfg_q !== 6'h00) $display("FAIL rq_cfg got=%h exp=00", cfg_q); else pass_cnt++;
    IOREQ_B = 1'b1; WR_B = 1'b1;
    repeat (2) @(negedge CLK);
    chk_cnt++; if (pulses - p0 !== 0) $display("FAIL rq_pulse got=%0d exp=0", pulses - p0); else pass_cnt++;
    io_write(8'hC7, 1'b0, 1'b1, 3);
    chk_cnt++; if (cfg_q !== 6'h07) $display("FAIL rq_fresh got=%h exp=07", cfg_q); else pass_cnt++;
    chk_cnt++; if (pulses - p0 !== 1) $display("FAIL rq_fresh_pulse got=%0d exp=1", pulses - p0); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic_write;
    test_mode5;
    test_rejects;
    test_mode3_min_qual;
    test_bank_limit;
    test_refresh;
    test_reset_in_qual;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
